// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - default parameters and helpers for the data_sync bus synchronizer
package data_sync_pkg;

    localparam int DATA_SYNC_STAGES  = 2;
    localparam int DATA_SYNC_WIDTH   = 8;
    localparam int DATA_SYNC_MIN_GAP = 4;

    // Gap counter must be able to hold min_gap itself (its saturation value).
    function automatic int gap_cnt_width(input int gap);
        return $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/ff_sync.sv
// rtl/ff_sync.sv - stages-deep single-bit synchronizer, async active-low reset to 0
module ff_sync #(
    parameter int stages = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [stages-1:0] chain;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[stages-2:0], i_d};
        end
    end

    assign o_q = chain[stages-1];

endmodule

// File: rtl/data_sync.sv
// rtl/data_sync.sv - enable-qualified bus synchronizer with pulse output; DATA_SYNC_OVERRUN_EN adds overrun flag
module data_sync
    import data_sync_pkg::*;
#(
    parameter int stages    = DATA_SYNC_STAGES,
    parameter int bus_width = DATA_SYNC_WIDTH,
    parameter int min_gap   = DATA_SYNC_MIN_GAP
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [bus_width-1:0] i_unsync_bus,
    input  logic                 i_bus_enable,
    output logic [bus_width-1:0] o_sync_bus,
    output logic                 o_enable_pulse
`ifdef DATA_SYNC_OVERRUN_EN
    ,
    input  logic                 i_overrun_clr,
    output logic                 o_overrun
`endif
);

    logic en_s;
    logic en_d;
    logic rise;

    ff_sync #(
        .stages(stages)
    ) u_en_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_bus_enable),
        .o_q  (en_s)
    );

    assign rise = en_s & ~en_d;

    // The bus is only sampled on rise, when the source holds it stable.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            en_d           <= 1'b0;
            o_sync_bus     <= '0;
            o_enable_pulse <= 1'b0;
        end else begin
            en_d           <= en_s;
            o_enable_pulse <= rise;
            if (rise) begin
                o_sync_bus <= i_unsync_bus;
            end
        end
    end

`ifdef DATA_SYNC_OVERRUN_EN
    localparam int cnt_w = gap_cnt_width(min_gap);
    localparam logic [cnt_w-1:0] gap_max = cnt_w'(min_gap);

    logic [cnt_w-1:0] gap_cnt;

    // Counter starts saturated so the first transfer after reset is never an overrun.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gap_cnt   <= gap_max;
            o_overrun <= 1'b0;
        end else begin
            if (rise) begin
                gap_cnt <= '0;
            end else if (gap_cnt != gap_max) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (rise && (gap_cnt < gap_max)) begin
                o_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                o_overrun <= 1'b0;
            end
        end
    end
`endif

endmodule
